// File: rtl/seq_detect_rr_scheduler.sv
// seq_detect_rr_scheduler: one shared sequence detector time-sliced across NUM_CH bit streams by a round-robin arbiter.
// Optional per-channel saturating hit counters are enabled with SEQ_DETECT_HIT_COUNT_EN.
module seq_detect_rr_scheduler #(
    parameter int NUM_CH = 4,
    parameter int CH_W   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] req_valid,
    input  logic [NUM_CH-1:0] req_bit,
    output logic [NUM_CH-1:0] req_ready,
    input  logic [NUM_CH-1:0] chan_clr,
`ifdef SEQ_DETECT_HIT_COUNT_EN
    input  logic [CH_W-1:0]   cnt_sel,
    output logic [7:0]        hit_cnt,
`endif
    output logic              dec_valid,
    output logic [CH_W-1:0]   dec_ch,
    output logic              ctx_busy
);

    typedef enum logic [3:0] {S0, S1, S2, S3, S4, S5, S6, S7, S8} state_t;

    state_t            ctx_q [NUM_CH];
    state_t            ctx_d [NUM_CH];
    logic [CH_W-1:0]   ptr_q, ptr_d;
    logic              dec_valid_q, dec_valid_d;
    logic [CH_W-1:0]   dec_ch_q, dec_ch_d;
    logic              ctx_busy_q, ctx_busy_d;
    logic [NUM_CH-1:0] elig;
    logic [CH_W-1:0]   idx, g;
    logic              found, hit;

    // Illegal encodings fall through to the S0 transitions.
    function automatic state_t nxt(input state_t s, input logic b);
        case (s)
            S0:      return b ? S1 : S0;
            S1:      return b ? S2 : S0;
            S2:      return b ? S3 : S0;
            S3:      return b ? S3 : S4;
            S4:      return b ? S1 : S5;
            S5:      return b ? S6 : S0;
            S6:      return b ? S8 : S7;
            S7:      return b ? S6 : S0;
            S8:      return b ? S3 : S0;
            default: return b ? S1 : S0;
        endcase
    endfunction

    always_comb begin
        elig  = req_valid & ~chan_clr;
        found = 1'b0;
        g     = '0;
        idx   = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            idx = CH_W'((int'(ptr_q) + k) % NUM_CH);
            if (!found && elig[idx]) begin
                found = 1'b1;
                g     = idx;
            end
        end
        req_ready = (found && !rst) ? NUM_CH'(1) << g : '0;
        hit       = found && ctx_q[g] == S8 && req_bit[g];
    end

    always_comb begin
        ctx_busy_d = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            ctx_d[i]   = chan_clr[i] ? S0 : (found && int'(g) == i) ? nxt(ctx_q[i], req_bit[i]) : ctx_q[i];
            ctx_busy_d = ctx_busy_d | (ctx_d[i] != S0);
        end
        ptr_d       = found ? ((int'(g) == NUM_CH - 1) ? '0 : g + 1'b1) : ptr_q;
        dec_valid_d = hit;
        dec_ch_d    = hit ? g : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) ctx_q[i] <= S0;
            ptr_q       <= '0;
            dec_valid_q <= 1'b0;
            dec_ch_q    <= '0;
            ctx_busy_q  <= 1'b0;
        end else begin
            ctx_q       <= ctx_d;
            ptr_q       <= ptr_d;
            dec_valid_q <= dec_valid_d;
            dec_ch_q    <= dec_ch_d;
            ctx_busy_q  <= ctx_busy_d;
        end
    end

    assign dec_valid = dec_valid_q;
    assign dec_ch    = dec_ch_q;
    assign ctx_busy  = ctx_busy_q;

`ifdef SEQ_DETECT_HIT_COUNT_EN
    logic [7:0] cnt_q [NUM_CH];
    logic [7:0] cnt_d [NUM_CH];

    always_comb begin
        for (int i = 0; i < NUM_CH; i++)
            cnt_d[i] = chan_clr[i] ? 8'd0 : (hit && int'(g) == i && cnt_q[i] != 8'hff) ? cnt_q[i] + 8'd1 : cnt_q[i];
        hit_cnt = (int'(cnt_sel) < NUM_CH) ? cnt_q[cnt_sel] : 8'd0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_seq_detect_rr_scheduler.sv
// tb_seq_detect_rr_scheduler: directed self-checking bench for seq_detect_rr_scheduler (NUM_CH=4).
module tb_seq_detect_rr_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req_valid, req_bit, req_ready, chan_clr;
    logic       dec_valid;
    logic [1:0] dec_ch;
    logic       ctx_busy;
`ifdef SEQ_DETECT_HIT_COUNT_EN
    logic [1:0] cnt_sel;
    logic [7:0] hit_cnt;
`endif

    int errs   = 0;
    int checks = 0;

    logic [7:0]  hp = 8'b1110_0111;
    logic [11:0] p1 = 12'b1110_0101_0111;
    logic [4:0]  pr = 5'b00111;

    always #5 clk = ~clk;

    seq_detect_rr_scheduler #(.NUM_CH(4), .CH_W(2)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_bit(req_bit),
        .req_ready(req_ready), .chan_clr(chan_clr),
`ifdef SEQ_DETECT_HIT_COUNT_EN
        .cnt_sel(cnt_sel), .hit_cnt(hit_cnt),
`endif
        .dec_valid(dec_valid), .dec_ch(dec_ch), .ctx_busy(ctx_busy)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int ch, input logic b, input logic hit);
        req_valid = 4'(1 << ch);
        req_bit   = b ? 4'hf : 4'h0;
        #1;
        chk("send_ready", 32'(req_ready), 32'(1 << ch));
        tick;
        chk("send_dec_valid", 32'(dec_valid), 32'(hit));
        chk("send_dec_ch", 32'(dec_ch), hit ? ch : 0);
        req_valid = '0;
    endtask

    task automatic clear_all;
        req_valid = '0;
        chan_clr  = 4'hf;
        tick;
        chan_clr  = '0;
    endtask

    initial begin
        rst = 1'b1; req_valid = 4'hf; req_bit = '0; chan_clr = '0;
`ifdef SEQ_DETECT_HIT_COUNT_EN
        cnt_sel = 2'd3;
`endif
        tick;
        tick;
        chk("rst_ready", 32'(req_ready), 0);
        rst = 1'b0; req_valid = '0;
        chk("rst_dec_valid", 32'(dec_valid), 0);
        chk("rst_dec_ch", 32'(dec_ch), 0);
        chk("rst_busy", 32'(ctx_busy), 0);

        // channel 0 alone: hit one cycle after the eighth bit
        for (int k = 0; k < 8; k++) send(0, hp[7-k], k == 7);
        chk("ch0_busy", 32'(ctx_busy), 1);
        tick;
        chk("ch0_idle_dv", 32'(dec_valid), 0);

        // channel 1 long pattern, then same pattern ending in 0
        clear_all;
        chk("clr_busy", 32'(ctx_busy), 0);
        for (int k = 0; k < 12; k++) send(1, p1[11-k], k == 11);
        clear_all;
        for (int k = 0; k < 12; k++) send(1, k == 11 ? 1'b0 : p1[11-k], 1'b0);

        // all four channels streaming after a fresh reset
        rst = 1'b1; tick; rst = 1'b0;
        for (int c = 0; c < 32; c++) begin
            req_valid = 4'hf;
            req_bit   = hp[7 - c/4] ? 4'hf : 4'h0;
            #1;
            chk("rr_grant", 32'(req_ready), 32'(1 << (c % 4)));
            tick;
            chk("rr_dv", 32'(dec_valid), 32'(c >= 28));
            chk("rr_ch", 32'(dec_ch), c >= 28 ? c - 28 : 0);
        end
        req_valid = '0;
        tick;
        chk("rr_tail_dv", 32'(dec_valid), 0);

        // clear beats a simultaneous request on channel 2
        clear_all;
        for (int k = 0; k < 3; k++) send(2, 1'b1, 1'b0);
        req_valid = 4'b0100; req_bit = 4'hf; chan_clr = 4'b0100;
        #1;
        chk("clr_ready", 32'(req_ready), 0);
        tick;
        chan_clr = '0; req_valid = '0;
        chk("clr2_busy", 32'(ctx_busy), 0);
        chk("clr2_dv", 32'(dec_valid), 0);
        for (int k = 0; k < 5; k++) send(2, pr[4-k], 1'b0);

        // reset in the middle of a stream
        clear_all;
        for (int k = 0; k < 7; k++) send(0, hp[7-k], 1'b0);
        chk("pre_rst_busy", 32'(ctx_busy), 1);
        rst = 1'b1; req_valid = 4'b0001; req_bit = 4'hf;
        #1;
        chk("mid_rst_ready", 32'(req_ready), 0);
        tick;
        rst = 1'b0; req_valid = '0;
        chk("mid_rst_dv", 32'(dec_valid), 0);
        chk("mid_rst_busy", 32'(ctx_busy), 0);
        req_valid = 4'hf; req_bit = 4'hf;
        #1;
        chk("mid_rst_ptr", 32'(req_ready), 1);
        tick;
        req_valid = '0;
        chk("mid_rst_nohit", 32'(dec_valid), 0);
        chk("mid_rst_busy1", 32'(ctx_busy), 1);

`ifdef SEQ_DETECT_HIT_COUNT_EN
        clear_all;
        cnt_sel = 2'd3;
        #1;
        chk("cnt_zero", 32'(hit_cnt), 0);
        for (int k = 0; k < 8; k++) send(3, hp[7-k], k == 7);
        chk("cnt_one", 32'(hit_cnt), 1);
        for (int h = 1; h < 300; h++)
            for (int k = 0; k < 5; k++) send(3, pr[4-k], k == 4);
        chk("cnt_sat", 32'(hit_cnt), 255);
        chan_clr = 4'b1000; tick; chan_clr = '0;
        chk("cnt_clr", 32'(hit_cnt), 0);
`endif

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/seq_detect_rr_scheduler.md
Name: seq_detect_rr_scheduler

Overview:
- Shares one sliding-window sequence-detection FSM between NUM_CH independent serial bit streams.
- Each cycle a round-robin arbiter grants at most one requesting channel.
- That channel's saved 4-bit detector state is restored, advanced by one bit and written back.
- A hit is reported with the channel id one cycle later.
- Sits between per-channel bit sources (valid/ready) and downstream hit-collection logic.

Parameters:
NUM_CH, 4, number of requesting channels (2..8)
CH_W, 2, channel id width, equal to clog2(NUM_CH)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
req_valid  input  NUM_CH  channel i has a bit to submit
req_bit  input  NUM_CH  bit value for channel i
req_ready  output  NUM_CH  one-hot grant; bit i accepted when req_valid[i] & req_ready[i]
chan_clr  input  NUM_CH  return channel i context to S0
dec_valid  output  1  registered: a hit was detected on the bit accepted last cycle
dec_ch  output  CH_W  channel of that hit; 0 when dec_valid=0
ctx_busy  output  1  registered: any channel context is not S0

Behaviour:
- Reset (rst=1 at posedge): all contexts S0, rr pointer 0, dec_valid 0, dec_ch 0, ctx_busy 0. req_ready is combinational and is 0 while rst=1.
- Detector (per channel, next state on bit 0/1):
  - S0: 0→S0, 1→S1
  - S1: 0→S0, 1→S2
  - S2: 0→S0, 1→S3
  - S3: 0→S4, 1→S3
  - S4: 0→S5, 1→S1
  - S5: 0→S0, 1→S6
  - S6: 0→S7, 1→S8
  - S7: 0→S0, 1→S6
  - S8: 0→S0, 1→S3
  - A hit is bit=1 accepted while the context is S8.
  - Encodings 9..15 are illegal and behave as S0.
- Arbitration:
  - Eligible channel: req_valid[i]=1 and chan_clr[i]=0.
  - Search starts at the rr pointer and ascends modulo NUM_CH; the first eligible channel g is granted and req_ready[g]=1.
  - All other req_ready bits are 0; at most one bit is 1.
  - req_ready depends only on state, req_valid and chan_clr (no path from req_bit).
- Accept cycle:
  - ctx[g] <= next(ctx[g], req_bit[g]).
  - Pointer <= (g+1) mod NUM_CH.
  - dec_valid <= hit; dec_ch <= hit ? g : 0.
  - Latency from accept to dec_valid is exactly 1 cycle.
- No eligible channel: pointer holds, dec_valid <= 0, dec_ch <= 0, no context changes.
- chan_clr[i]=1: ctx[i] <= S0 that edge. Channel i is masked from arbitration that cycle, so clear wins over a simultaneous request and that bit is not accepted. Clearing a channel does not affect other channels or the pointer.
- ctx_busy <= OR over i of (next-cycle ctx[i] != S0).
- Reset mid-stream discards all partial contexts and any pending dec_valid.
- Starvation bound: a continuously valid, uncleared channel is granted within NUM_CH cycles.

Optional Feature:
- Macro: SEQ_DETECT_HIT_COUNT_EN
- Defined:
  - Adds input cnt_sel[CH_W-1:0] and output hit_cnt[7:0].
  - One 8-bit saturating hit counter per channel increments on that channel's hit (same edge dec_valid is set).
  - Holds at 255; zeroed by rst or chan_clr[i].
  - hit_cnt = count[cnt_sel], combinational.
- Undefined: no extra ports, no counter registers. All other behaviour is identical.

Test Plan:
- Reset then channel 0 alone sends 1,1,1,0,0,1,1,1 → req_ready[0]=1 each cycle; dec_valid=1 with dec_ch=0 exactly one cycle after the 8th bit, and 0 on all other cycles.
- Channel 1 sends 1,1,1,0,0,1,0,1,0,1,1,1 → a single hit one cycle after the last bit; a 0 in place of that last bit gives no hit.
- All 4 channels continuously valid, each streaming the 8-bit hit pattern → grants cycle 0,1,2,3,0,…; each channel hits once; dec_ch sequence is 0,1,2,3 on consecutive cycles.
- Channel 2 valid with chan_clr[2]=1 in the same cycle after 1,1,1 → req_ready[2]=0; the context is S0; a following 0,0,1,1,1 produces no hit.
- rst asserted after channel 0 has taken 1,1,1,0,0,1,1 → next bit 1 produces no hit; dec_valid=0, ctx_busy=0 and the pointer is 0 after reset.
- With SEQ_DETECT_HIT_COUNT_EN defined, 300 hits on channel 3 → hit_cnt=255 with cnt_sel=3; chan_clr[3] pulse → 0.
